// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of every non-clock signal of alu_arbiter.
//   req0_*/req1_* : request channels (valid/ready, operands a/b, op code)
//   rsp0_*/rsp1_* : response channels (valid/ready), sharing rsp_result,
//                   rsp_zero and rsp_err
//   alu_*         : connection to the shared ALU (operands/control out,
//                   result/zero in)
//   busy          : arbiter is not idle
// Modports: master = requesters plus shared ALU (environment side),
//           slave  = the arbiter itself.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_op;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;
  logic [DATA_W-1:0] alu_in_1;
  logic [DATA_W-1:0] alu_in_2;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  alu_in_1, alu_in_2, alu_ctrl,
    output alu_result, alu_zero,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output alu_in_1, alu_in_2, alu_ctrl,
    input  alu_result, alu_zero,
    output busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- shares one ALU between two requesters.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : alu_arbiter_if.slave (request/response channels, ALU link, busy)
// One operation at a time: IDLE accepts a request (round-robin on
// contention), EXEC samples the ALU for one cycle, RESP holds the result
// until the owning requester consumes it.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;

  state_t            state_reg, state_next;
  logic              last_grant_reg;
  logic              owner_reg;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [3:0]        op_reg;
  logic [DATA_W-1:0] result_reg;
  logic              zero_reg;
  logic              err_reg;

  logic any_valid;
  logic grant;
  logic accept;
  logic op_ok;
  logic rsp_fire;

  // Grant: a lone requester wins; on contention the one not served last.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_reg;
    end else begin
      grant = bus.req1_valid;
    end
  end

  // Readies are gated by rst so they drop the instant reset asserts.
  assign accept         = (state_reg == IDLE) && any_valid && !rst;
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  assign rsp_fire = (state_reg == RESP) &&
                    (owner_reg ? bus.rsp1_ready : bus.rsp0_ready);

  always_comb begin
    op_ok = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB, OP_XOR, OP_OR: op_ok = 1'b1;
      default:                       op_ok = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the granted request; sample the ALU during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= 4'b0000;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (accept) begin
        owner_reg      <= grant;
        last_grant_reg <= grant;
        a_reg          <= grant ? bus.req1_a  : bus.req0_a;
        b_reg          <= grant ? bus.req1_b  : bus.req0_b;
        op_reg         <= grant ? bus.req1_op : bus.req0_op;
      end
      if (state_reg == EXEC) begin
        if (op_ok) begin
          result_reg <= bus.alu_result;
          zero_reg   <= bus.alu_zero;
          err_reg    <= 1'b0;
        end else begin
          // Unknown op: the ALU's answer is meaningless, report an error.
          result_reg <= '0;
          zero_reg   <= 1'b0;
          err_reg    <= 1'b1;
        end
      end
    end
  end

  // The ALU only ever sees captured operands.
  assign bus.alu_in_1 = a_reg;
  assign bus.alu_in_2 = b_reg;
  assign bus.alu_ctrl = op_reg;

  assign bus.rsp0_valid = (state_reg == RESP) && !owner_reg && !rst;
  assign bus.rsp1_valid = (state_reg == RESP) &&  owner_reg && !rst;
  assign bus.rsp_result = result_reg;
  assign bus.rsp_zero   = zero_reg;
  assign bus.rsp_err    = err_reg;
  assign bus.busy       = (state_reg != IDLE) && !rst;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- self-checking bench for alu_arbiter.
// Emulates the shared ALU, keeps a transaction-level model of the arbiter,
// compares every output on each falling edge and adds literal checks for
// the directed scenarios.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(W)) bus();
  alu_arbiter #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic defined by the op-code table.
  function automatic logic [W-1:0] spec_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a ^ b;
      4'b0001: return a | b;
      default: return '0;
    endcase
  endfunction

  function automatic bit supported(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0110) || (op == 4'b0000) || (op == 4'b0001);
  endfunction

  // Shared ALU emulation; alu_corrupt makes it return garbage.
  logic alu_corrupt = 1'b0;
  always_comb begin
    if (alu_corrupt) begin
      bus.alu_result = 32'hDEADBEEF;
      bus.alu_zero   = 1'b1;
    end else begin
      bus.alu_result = spec_op(bus.alu_ctrl, bus.alu_in_1, bus.alu_in_2);
      bus.alu_zero   = (spec_op(bus.alu_ctrl, bus.alu_in_1, bus.alu_in_2) == '0);
    end
  end

  // Transaction model: one operation in flight, visible one cycle after accept.
  bit         m_busy = 0, m_rsp = 0, m_own = 0, m_last = 1;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0] m_op = 4'b0000;
  bit         m_zero = 0, m_err = 0;
  int         acc_cnt = 0, done_cnt = 0;
  bit         acc_q[$];
  bit         log_zero[$], log_err[$];
  logic [W-1:0] log_res[$];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_rsp = 0; m_last = 1;
      m_a = '0; m_b = '0; m_op = 4'b0000; m_res = '0; m_zero = 0; m_err = 0;
    end else if (!m_busy) begin
      if (bus.req0_valid || bus.req1_valid) begin
        m_own  = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        m_last = m_own;
        m_a    = m_own ? bus.req1_a  : bus.req0_a;
        m_b    = m_own ? bus.req1_b  : bus.req0_b;
        m_op   = m_own ? bus.req1_op : bus.req0_op;
        m_err  = !supported(m_op);
        m_res  = m_err ? '0 : spec_op(m_op, m_a, m_b);
        m_zero = !m_err && (m_res == '0);
        m_busy = 1; m_rsp = 0;
        acc_cnt++;
        acc_q.push_back(m_own);
      end
    end else if (!m_rsp) begin
      m_rsp = 1;
    end else if (m_own ? bus.rsp1_ready : bus.rsp0_ready) begin
      log_res.push_back(m_res); log_zero.push_back(m_zero); log_err.push_back(m_err);
      $display("txn %0d owner=%0d op=%b a=%h b=%h result=%h zero=%0d err=%0d",
               done_cnt, m_own, m_op, m_a, m_b, m_res, m_zero, m_err);
      m_busy = 0; m_rsp = 0;
      done_cnt++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_req0_ready", bus.req0_ready, 1'b0);
      chk1("rst_req1_ready", bus.req1_ready, 1'b0);
      chk1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
    end else begin
      bit any, g;
      any = bus.req0_valid || bus.req1_valid;
      g   = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
      chk1("req0_ready", bus.req0_ready, !m_busy && any && !g);
      chk1("req1_ready", bus.req1_ready, !m_busy && any && g);
      chk1("busy", bus.busy, m_busy);
      chk1("rsp0_valid", bus.rsp0_valid, m_rsp && !m_own);
      chk1("rsp1_valid", bus.rsp1_valid, m_rsp && m_own);
      chkw("alu_in_1", bus.alu_in_1, m_a);
      chkw("alu_in_2", bus.alu_in_2, m_b);
      chkw("alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, m_op});
      if (m_rsp) begin
        chkw("rsp_result", bus.rsp_result, m_res);
        chk1("rsp_zero", bus.rsp_zero, m_zero);
        chk1("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 20) begin tick(); n++; end
    chk1("accept_timeout", acc_cnt >= target, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin tick(); n++; end
    chk1("done_timeout", done_cnt >= target, 1'b1);
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 4'b0000;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 4'b0000;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;

    // Reset state
    repeat (2) tick();
    rst = 0;
    tick();
    chkw("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chkw("rst_alu_in_1", bus.alu_in_1, 32'd0);
    chkw("rst_result", bus.rsp_result, 32'd0);

    // S1: req0 add 5+7 with fixed latency
    bus.req0_valid = 1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_op = 4'b0010;
    wait_acc(1);
    bus.req0_valid = 0;
    chk1("s1_exec_busy", bus.busy, 1'b1);
    chk1("s1_exec_rspv", bus.rsp0_valid, 1'b0);
    tick();
    chk1("s1_rspv", bus.rsp0_valid, 1'b1);
    chkw("s1_result", bus.rsp_result, 32'd12);
    chk1("s1_zero", bus.rsp_zero, 1'b0);
    chk1("s1_err", bus.rsp_err, 1'b0);
    bus.rsp0_ready = 1;
    wait_done(1);
    bus.rsp0_ready = 0;

    // S2: both valid after reset -> order 0,1,0
    rst = 1; tick(); rst = 0; tick();
    bus.req0_valid = 1; bus.req0_a = 32'd9;    bus.req0_b = 32'd9;    bus.req0_op = 4'b0110;
    bus.req1_valid = 1; bus.req1_a = 32'hF0;   bus.req1_b = 32'h0F;   bus.req1_op = 4'b0001;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    wait_done(4);
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    chk1("s2_order0", acc_q[1], 1'b0);
    chk1("s2_order1", acc_q[2], 1'b1);
    chk1("s2_order2", acc_q[3], 1'b0);
    chkw("s2_sub_result", log_res[1], 32'd0);
    chk1("s2_sub_zero", log_zero[1], 1'b1);
    chkw("s2_or_result", log_res[2], 32'hFF);

    // S3: unsupported op on req1, ALU returning garbage
    alu_corrupt = 1;
    bus.req1_valid = 1; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_op = 4'b0111;
    wait_acc(5);
    bus.req1_valid = 0;
    bus.rsp1_ready = 1;
    wait_done(5);
    bus.rsp1_ready = 0;
    alu_corrupt = 0;
    chkw("s3_result", log_res[4], 32'd0);
    chk1("s3_zero", log_zero[4], 1'b0);
    chk1("s3_err", log_err[4], 1'b1);

    // S4: rsp0 back-pressure while req1 waits
    bus.req0_valid = 1; bus.req0_a = 32'd10; bus.req0_b = 32'd20; bus.req0_op = 4'b0010;
    wait_acc(6);
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_op = 4'b0001;
    bus.rsp1_ready = 1;  // non-owner ready must be ignored
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("s4_rspv_hold", bus.rsp0_valid, 1'b1);
      chk1("s4_busy_hold", bus.busy, 1'b1);
      chk1("s4_req1_ready", bus.req1_ready, 1'b0);
      chkw("s4_result_hold", bus.rsp_result, 32'd30);
      tick();
    end
    bus.rsp0_ready = 1;
    wait_done(6);
    bus.rsp0_ready = 0;
    wait_acc(7);
    bus.req1_valid = 0;
    wait_done(7);
    bus.rsp1_ready = 0;
    chkw("s4_req1_result", log_res[6], 32'd3);

    // S5: reset during EXEC discards the operation
    bus.req0_valid = 1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_op = 4'b0010;
    wait_acc(8);
    bus.req0_valid = 0;
    chk1("s5_in_exec", bus.busy, 1'b1);
    rst = 1;
    #1;
    chk1("s5_busy_now", bus.busy, 1'b0);
    chk1("s5_rspv_now", bus.rsp0_valid, 1'b0);
    tick(); tick();
    rst = 0;
    bus.rsp0_ready = 1;
    repeat (5) begin
      chk1("s5_no_rsp", bus.rsp0_valid, 1'b0);
      tick();
    end
    bus.rsp0_ready = 0;
    chkw("s5_done_cnt", done_cnt, 32'd7);

    // S6: wrap-around add
    bus.req0_valid = 1; bus.req0_a = 32'hFFFFFFFF; bus.req0_b = 32'd1; bus.req0_op = 4'b0010;
    wait_acc(9);
    bus.req0_valid = 0;
    bus.rsp0_ready = 1;
    wait_done(8);
    bus.rsp0_ready = 0;
    chkw("s6_result", log_res[7], 32'd0);
    chk1("s6_zero", log_zero[7], 1'b1);
    chkw("log_size", log_res.size(), 32'd8);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
